muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. It consumes the two source operands read from the register file and produces a 32-bit result plus a one-cycle write-enable/destination pair for the register-file write port. The core stalls on `busy` while an operation is in flight. One operation is in flight at a time; there is no pipelining.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; accepted only when `busy`=0.
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data`  in  32  operand A (dividend / multiplicand).
- `rs2_data`  in  32  operand B (divisor / multiplier).
- `rd_in`  in  5  destination register of the request.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  32  final value; held until the next `done`.
- `wb_en`  out  1  = `done` && (`rd_out` ≠ 0); drives the register-file write enable.
- `rd_out`  out  5  latched `rd_in`; held until the next accepted start.

## Operation
- State machine: IDLE → CALC → DONE → IDLE. Special-case divides go IDLE → DONE directly.
- **IDLE.** On `start`=1 at a clock edge, latch `funct3` and `rd_in`.
  - Convert each operand to its magnitude when that operand is signed:
    - MUL/MULH/DIV/REM: both operands signed.
    - MULHSU: A signed, B unsigned.
    - MULHU/DIVU/REMU: both unsigned.
  - Record the result sign:
    - Product and quotient: signA XOR signB.
    - Remainder: signA.
  - Clear the 6-bit iteration counter.
- **CALC.** Exactly 32 iterations, one per cycle; counter runs 0..31. Leave CALC when the counter reaches 31.
  - Multiply: shift-add over a 64-bit accumulator, consuming B LSB-first.
  - Divide: restoring shift-subtract, producing one quotient bit per cycle.
- **DONE.** One cycle with `done`=1.
  - Apply sign correction (two's-complement negate if the recorded sign is set).
  - Select the result:
    - MUL: low 32 bits of the product.
    - MULH/MULHSU/MULHU: high 32 bits of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Return to IDLE.
- **Special cases.** Detected in IDLE at accept; skip CALC and enter DONE at the next edge.
  - Divide by zero (B=0), any div/rem op: quotient = 0xFFFFFFFF; remainder = A (unmodified).
  - Signed overflow, DIV/REM with A=0x80000000 and B=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- **`start` while `busy`=1** (CALC or DONE): ignored, no side effects. The requester must hold or re-issue the request.
- **Reset:** forces state IDLE and counter 0. All outputs are 0 (`busy`, `done`, `wb_en`, `result`, `rd_out`). Reset mid-CALC aborts the operation with no `done` and no `wb_en`.
- **`rd_in`=0:** the operation runs normally and `done` pulses, but `wb_en` stays 0.

## Timing
- Accept edge = edge k, where `start`=1 and `busy`=0.
- Normal op:
  - `busy`=1 from after edge k through the DONE cycle.
  - CALC occupies cycles after edges k..k+31.
  - DONE is the cycle after edge k+32, with `done`/`wb_en`/`result` valid.
  - `busy`=0 after edge k+33.
  - Latency: 33 cycles from accept to `done`; throughput one op per 34 cycles.
- Special-case divide: `done` in the cycle after edge k (latency 1).
- The earliest next accept is the edge that ends the DONE cycle's successor, i.e. `start` sampled while `busy`=0 again.
- `result` and `rd_out` are registered and stable for the whole DONE cycle. The register file samples them at the edge ending DONE.
- Operand inputs are sampled only at the accept edge and may change afterward.

## Test plan
- **MUL:** `rs1_data`=7, `rs2_data`=6, `rd_in`=5 → `done` 33 cycles after accept, `result`=42, `wb_en`=1, `rd_out`=5.
- **MULH / MULHSU / MULHU:** A=0xFFFFFFFF (−1), B=0xFFFFFFFF → MULH `result`=0x00000000; MULHU `result`=0xFFFFFFFE; MULHSU `result`=0xFFFFFFFF.
- **DIV/REM signs:** A=−7 (0xFFFFFFF9), B=2 → DIV `result`=0xFFFFFFFD (−3); REM `result`=0xFFFFFFFF (−1); DIVU `result`=0x7FFFFFFC.
- **Special cases:**
  - DIV A=5, B=0 → `result`=0xFFFFFFFF, `done` 1 cycle after accept.
  - REM A=5, B=0 → `result`=5.
  - DIV A=0x80000000, B=0xFFFFFFFF → `result`=0x80000000.
  - REM with the same operands → `result`=0.
- **Busy/rd handling:**
  - Pulse `start` every cycle during an op → only the first is accepted, exactly one `done` per accepted op.
  - `rd_in`=0 → `done`=1, `wb_en`=0.
- **Reset:** assert `rst` for one cycle at CALC counter 10 → next cycle `busy`=0, `result`=0; no `done` ever appears for the aborted op. A new MUL 3×4 then returns 12.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one operation in flight, 32 CALC cycles,
// sign handled by magnitude datapath plus a final negate.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            wb_en,
  output logic [4:0]      rd_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      LAST_IT = 6'(XLEN-1);

  logic [1:0]        state;
  logic [5:0]        cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;

  // ---------------- request decode ----------------
  logic            sgn_a_en, sgn_b_en;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_div, is_rem;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    sgn_a_en = 1'b0;
    sgn_b_en = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sgn_a_en = 1'b1;
        sgn_b_en = 1'b1;
      end
      3'b010:  sgn_a_en = 1'b1;
      default: ;
    endcase
  end

  assign a_neg  = sgn_a_en & rs1_data[XLEN-1];
  assign b_neg  = sgn_b_en & rs2_data[XLEN-1];
  assign a_mag  = a_neg ? -rs1_data : rs1_data;
  assign b_mag  = b_neg ? -rs2_data : rs2_data;
  assign is_div = funct3[2];
  assign is_rem = funct3[2] & funct3[1];

  // Special divides bypass CALC; the remainder of a divide-by-zero is the raw dividend.
  assign div_zero = is_div && (rs2_data == '0);
  assign div_ovf  = is_div && !funct3[0] && (rs1_data == MIN_INT) && (rs2_data == '1);

  always_comb begin
    if (div_zero) special_res = is_rem ? rs1_data : '1;
    else          special_res = is_rem ? '0 : MIN_INT;
  end

  // ---------------- one iteration ----------------
  // acc holds {hi, lo}: multiply = {partial product, remaining multiplier},
  // divide = {partial remainder, dividend shifting into quotient}.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_nxt;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
  assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};

  always_comb begin
    if (op_q[2]) begin
      if (div_diff[XLEN])
        acc_nxt = {acc_q[2*XLEN-2:XLEN-1], acc_q[XLEN-2:0], 1'b0};
      else
        acc_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      if (acc_q[0])
        acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
      else
        acc_nxt = {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  // ---------------- sign correction and select ----------------
  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    mul_fix = neg_q ? -acc_nxt : acc_nxt;
    quo     = acc_nxt[XLEN-1:0];
    rem     = acc_nxt[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 final_res = mul_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = mul_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = neg_q ? -quo : quo;
      default:                final_res = neg_q ? -rem : rem;
    endcase
  end

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= funct3;
            rd_out <= rd_in;
            cnt    <= '0;
            neg_q  <= is_rem ? a_neg : (a_neg ^ b_neg);
            opnd_q <= is_div ? b_mag : a_mag;
            acc_q  <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            if (div_zero || div_ovf) begin
              result <= special_res;
              state  <= S_DONE;
            end else begin
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_nxt;
          cnt   <= cnt + 6'd1;
          if (cnt == LAST_IT) begin
            result <= final_res;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign wb_en = done && (rd_out != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: per-feature tasks with inline checks.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .wb_en(wb_en), .rd_out(rd_out)
  );

  // Issue one request, scramble operands after accept, wait (bounded) for done.
  // lat = 1 means done seen right after the accept edge; -1 means timeout.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output logic [31:0] res,
                       output logic wb, output logic [4:0] rdo, output logic busy_after);
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h1234_5678; rd_in = 5'd31;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
    res = result; wb = wb_en; rdo = rd_out;
    @(posedge clk); #1;
    busy_after = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (wb_en !== 1'b0)  begin bad++; $display("FAIL reset_wb_en got=%b exp=0", wb_en); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if (rd_out !== 5'd0) begin bad++; $display("FAIL reset_rd_out got=%0d exp=0", rd_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul;
    int lat; logic [31:0] r; logic w; logic [4:0] d; logic ba;
    do_op(3'b000, 32'd7, 32'd6, 5'd5, lat, r, w, d, ba);
    total++; if (lat !== 33)     begin bad++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    total++; if (r !== 32'd42)   begin bad++; $display("FAIL mul_result got=%h exp=%h", r, 32'd42); end
    total++; if (w !== 1'b1)     begin bad++; $display("FAIL mul_wb_en got=%b exp=1", w); end
    total++; if (d !== 5'd5)     begin bad++; $display("FAIL mul_rd_out got=%0d exp=5", d); end
    total++; if (ba !== 1'b0)    begin bad++; $display("FAIL mul_busy_after got=%b exp=0", ba); end
  endtask

  task automatic test_mulh;
    logic [2:0]  ops [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] exp [3] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int lat; logic [31:0] r; logic w; logic [4:0] d; logic ba;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, lat, r, w, d, ba);
      total++;
      if (lat !== 33 || r !== exp[i]) begin
        bad++;
        $display("FAIL mulh_op%0d got=%h lat=%0d exp=%h lat=33", ops[i], r, lat, exp[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [3] = '{3'b100, 3'b110, 3'b101};
    logic [31:0] exp [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
    int lat; logic [31:0] r; logic w; logic [4:0] d; logic ba;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], 32'hFFFF_FFF9, 32'd2, 5'd11, lat, r, w, d, ba);
      total++;
      if (lat !== 33 || r !== exp[i]) begin
        bad++;
        $display("FAIL div_op%0d got=%h lat=%0d exp=%h lat=33", ops[i], r, lat, exp[i]);
      end
    end
  endtask

  task automatic test_special;
    logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    int lat; logic [31:0] r; logic w; logic [4:0] d; logic ba;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], 5'd12, lat, r, w, d, ba);
      total++;
      if (lat !== 1 || r !== exp[i] || w !== 1'b1) begin
        bad++;
        $display("FAIL special_%0d got=%h lat=%0d wb=%b exp=%h lat=1 wb=1", i, r, lat, w, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n_done = 0; int done_at = -1; logic busy_mid = 1'b0; logic [31:0] r = '0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd5; rd_in = 5'd7;
    @(posedge clk); #1;
    rs1_data = 32'd100; rs2_data = 32'd100; rd_in = 5'd9;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) busy_mid = busy;
      if (i == 33) start = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        if (done_at < 0) begin done_at = i; r = result; end
      end
    end
    total++; if (busy_mid !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy_mid); end
    total++; if (n_done !== 1)  begin bad++; $display("FAIL b2b_done_count got=%0d exp=1", n_done); end
    total++; if (done_at !== 32) begin bad++; $display("FAIL b2b_done_edge got=%0d exp=32", done_at); end
    total++; if (r !== 32'd15)  begin bad++; $display("FAIL b2b_result got=%h exp=%h", r, 32'd15); end
    total++; if (rd_out !== 5'd7) begin bad++; $display("FAIL b2b_rd_out got=%0d exp=7", rd_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_rd0;
    int lat; logic [31:0] r; logic w; logic [4:0] d; logic ba;
    do_op(3'b000, 32'd9, 32'd9, 5'd0, lat, r, w, d, ba);
    total++; if (lat !== 33)   begin bad++; $display("FAIL rd0_done got=%0d exp=33", lat); end
    total++; if (w !== 1'b0)   begin bad++; $display("FAIL rd0_wb_en got=%b exp=0", w); end
    total++; if (r !== 32'd81) begin bad++; $display("FAIL rd0_result got=%h exp=%h", r, 32'd81); end
  endtask

  task automatic test_reset_mid;
    int n_done = 0;
    int lat; logic [31:0] r; logic w; logic [4:0] d; logic ba;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9; rd_in = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h exp=0", result); end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || wb_en === 1'b1) n_done++;
    end
    total++; if (n_done !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", n_done); end
    do_op(3'b000, 32'd3, 32'd4, 5'd4, lat, r, w, d, ba);
    total++; if (lat !== 33 || r !== 32'd12) begin
      bad++; $display("FAIL rstmid_next_mul got=%h lat=%0d exp=%h lat=33", r, lat, 32'd12);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_mulh;
    test_div;
    test_special;
    test_back_to_back;
    test_rd0;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
